// File: rtl/pcm_pkg.sv
// Shared constants and types for the PCM/VROM address demux (pcm_sync_mux).
package pcm_pkg;

    localparam int          PCM_AW_DEF       = 24;
    localparam logic [23:0] PCM_P_OFFSET_DEF = 24'h200000;
    localparam int          CNT_W            = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/pcm_mpx_latch.sv
// Synchronises one MPX strobe, detects its edges and latches the two address halves
// from an equally delayed copy of the bus.
module pcm_mpx_latch #(
    parameter int HW          = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mpx,
    input  logic [HW-1:0]     bus,
    output logic [2*HW-1:0]   lat,
    output logic              hi_done
);

    logic [SYNC_STAGES-1:0]         mpx_sync_q, mpx_sync_d;
    logic [SYNC_STAGES-1:0][HW-1:0] bus_dly_q, bus_dly_d;
    logic                           mpx_prev_q, mpx_prev_d;
    logic [2*HW-1:0]                lat_q, lat_d;
    logic                           hi_done_q, hi_done_d;
    logic                           mpx_s, rise, fall;

    // The bus travels through the same number of flops as the strobe, so the
    // delayed bus value lines up with the cycle in which the edge is seen.
    always_comb begin
        mpx_sync_d = {mpx_sync_q[SYNC_STAGES-2:0], mpx};
        bus_dly_d  = {bus_dly_q[SYNC_STAGES-2:0], bus};
        mpx_s      = mpx_sync_q[SYNC_STAGES-1];
        rise       = mpx_s & ~mpx_prev_q;
        fall       = ~mpx_s & mpx_prev_q;
        mpx_prev_d = mpx_s;
        lat_d      = lat_q;
        if (rise) lat_d[HW-1:0]    = bus_dly_q[SYNC_STAGES-1];
        if (fall) lat_d[2*HW-1:HW] = bus_dly_q[SYNC_STAGES-1];
        hi_done_d  = fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpx_sync_q <= '0;
            bus_dly_q  <= '0;
            mpx_prev_q <= 1'b0;
            lat_q      <= '0;
            hi_done_q  <= 1'b0;
        end else begin
            mpx_sync_q <= mpx_sync_d;
            bus_dly_q  <= bus_dly_d;
            mpx_prev_q <= mpx_prev_d;
            lat_q      <= lat_d;
            hi_done_q  <= hi_done_d;
        end
    end

    assign lat     = lat_q;
    assign hi_done = hi_done_q;

endmodule

// File: rtl/pcm_sync_mux.sv
// YM2610 ADPCM-A/B to V-ROM address demux with read-hold data latch.
// Optional PCM_BANK_EN adds a BANK input overriding the top 4 bits of the P address.
module pcm_sync_mux
    import pcm_pkg::*;
#(
    parameter int          AW          = PCM_AW_DEF,
    parameter int          SYNC_STAGES = 2,
    parameter int          HOLD_CYCLES = 5,
    parameter logic [23:0] P_OFFSET    = PCM_P_OFFSET_DEF
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic          MODE,
    input  logic          nSDROE,
    input  logic          SDRMPX,
    input  logic [7:0]    SDRAD_I,
    output logic [7:0]    SDRAD_O,
    output logic          SDRAD_OE,
    input  logic [1:0]    SDRA_L,
    input  logic [3:0]    SDRA_U,
    input  logic          nSDPOE,
    input  logic          SDPMPX,
    input  logic [7:0]    SDPAD_I,
    output logic [7:0]    SDPAD_O,
    output logic          SDPAD_OE,
    input  logic [3:0]    SDPA,
`ifdef PCM_BANK_EN
    input  logic [3:0]    BANK,
`endif
    input  logic [7:0]    D,
    output logic [AW-1:0] A,
    output logic          A_VALID
);

    if (AW < 24 || SYNC_STAGES < 2 || HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_param
        $error("pcm_sync_mux: illegal AW/SYNC_STAGES/HOLD_CYCLES");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [19:0] r_lat;
    logic [23:0] p_lat;
    logic        r_hi_done, p_hi_done;

    pcm_mpx_latch #(.HW(10), .SYNC_STAGES(SYNC_STAGES)) u_r_latch (
        .clk     (CLK),
        .rst_n   (nRESET),
        .mpx     (SDRMPX),
        .bus     ({SDRA_L, SDRAD_I}),
        .lat     (r_lat),
        .hi_done (r_hi_done)
    );

    pcm_mpx_latch #(.HW(12), .SYNC_STAGES(SYNC_STAGES)) u_p_latch (
        .clk     (CLK),
        .rst_n   (nRESET),
        .mpx     (SDPMPX),
        .bus     ({SDPA, SDPAD_I}),
        .lat     (p_lat),
        .hi_done (p_hi_done)
    );

    logic [SYNC_STAGES-1:0] r_oe_sync_q, r_oe_sync_d;
    logic [SYNC_STAGES-1:0] p_oe_sync_q, p_oe_sync_d;
    logic                   r_oe_n_s, p_oe_n_s, sel_p;
    logic                   sel_prev_q, sel_prev_d;
    logic [AW-1:0]          a_q, a_d, p_addr, r_addr;
    logic                   a_valid_q, a_valid_d;
    logic [3:0]             bank_q, bank_d;
    rd_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             dlat_q, dlat_d;

    always_comb begin
        r_oe_sync_d = {r_oe_sync_q[SYNC_STAGES-2:0], nSDROE};
        p_oe_sync_d = {p_oe_sync_q[SYNC_STAGES-2:0], nSDPOE};
        r_oe_n_s    = r_oe_sync_q[SYNC_STAGES-1];
        p_oe_n_s    = p_oe_sync_q[SYNC_STAGES-1];
        sel_p       = ~p_oe_n_s;
        sel_prev_d  = sel_p;

`ifdef PCM_BANK_EN
        bank_d = p_hi_done ? BANK : bank_q;
`else
        bank_d = 4'h0;
`endif
        p_addr        = '0;
        p_addr[23:0]  = p_lat | (MODE ? P_OFFSET : 24'h0);
`ifdef PCM_BANK_EN
        p_addr[AW-1 -: 4] = bank_d;
`endif
        r_addr        = '0;
        r_addr[23:0]  = {SDRA_U, r_lat};
        a_d           = sel_p ? p_addr : r_addr;
        a_valid_d     = (sel_p ? p_hi_done : r_hi_done) | (sel_p != sel_prev_q);
    end

    // Read-hold FSM: P activity pins the counter at 0 so R never latches mid-P-read.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dlat_d  = dlat_q;
        if (r_oe_n_s) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (p_oe_n_s) begin
                        state_d = COUNT;
                        cnt_d   = '0;
                    end
                end
                COUNT: begin
                    if (!p_oe_n_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        dlat_d  = D;
                        state_d = HOLD;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HOLD: state_d = HOLD;
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_oe_sync_q <= '1;
            p_oe_sync_q <= '1;
            sel_prev_q  <= 1'b0;
            a_q         <= '0;
            a_valid_q   <= 1'b0;
            bank_q      <= 4'h0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            dlat_q      <= 8'h00;
        end else begin
            r_oe_sync_q <= r_oe_sync_d;
            p_oe_sync_q <= p_oe_sync_d;
            sel_prev_q  <= sel_prev_d;
            a_q         <= a_d;
            a_valid_q   <= a_valid_d;
            bank_q      <= bank_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dlat_q      <= dlat_d;
        end
    end

    assign A        = a_q;
    assign A_VALID  = a_valid_q;
    assign SDRAD_O  = (state_q == HOLD) ? dlat_q : D;
    assign SDRAD_OE = ~r_oe_n_s;
    assign SDPAD_OE = ~p_oe_n_s;
    assign SDPAD_O  = D;

endmodule

// File: tb/tb_pcm_sync_mux.sv
// Directed bench for pcm_sync_mux (default parameters: AW=24, SYNC_STAGES=2, HOLD_CYCLES=5).
module tb_pcm_sync_mux;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        MODE;
    logic        nSDROE;
    logic        SDRMPX;
    logic [7:0]  SDRAD_I;
    logic [7:0]  SDRAD_O;
    logic        SDRAD_OE;
    logic [1:0]  SDRA_L;
    logic [3:0]  SDRA_U;
    logic        nSDPOE;
    logic        SDPMPX;
    logic [7:0]  SDPAD_I;
    logic [7:0]  SDPAD_O;
    logic        SDPAD_OE;
    logic [3:0]  SDPA;
`ifdef PCM_BANK_EN
    logic [3:0]  BANK;
`endif
    logic [7:0]  D;
    logic [23:0] A;
    logic        A_VALID;

    int n_cmp = 0;
    int n_err = 0;

    pcm_sync_mux dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .MODE     (MODE),
        .nSDROE   (nSDROE),
        .SDRMPX   (SDRMPX),
        .SDRAD_I  (SDRAD_I),
        .SDRAD_O  (SDRAD_O),
        .SDRAD_OE (SDRAD_OE),
        .SDRA_L   (SDRA_L),
        .SDRA_U   (SDRA_U),
        .nSDPOE   (nSDPOE),
        .SDPMPX   (SDPMPX),
        .SDPAD_I  (SDPAD_I),
        .SDPAD_O  (SDPAD_O),
        .SDPAD_OE (SDPAD_OE),
        .SDPA     (SDPA),
`ifdef PCM_BANK_EN
        .BANK     (BANK),
`endif
        .D        (D),
        .A        (A),
        .A_VALID  (A_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        nRESET = 1'b0; MODE = 1'b0; nSDROE = 1'b1; nSDPOE = 1'b1;
        SDRMPX = 1'b0; SDRAD_I = 8'h00; SDRA_L = 2'd0; SDRA_U = 4'h3;
        SDPMPX = 1'b0; SDPAD_I = 8'h00; SDPA = 4'h0; D = 8'h00;
`ifdef PCM_BANK_EN
        BANK = 4'h0;
`endif
        step(2);
        check("rst_A", 32'(A), 32'h0);
        check("rst_AV", 32'(A_VALID), 32'h0);
        check("rst_ROE", 32'(SDRAD_OE), 32'h0);
        check("rst_POE", 32'(SDPAD_OE), 32'h0);
        nRESET = 1'b1;
        step(2);
        check("post_rst_A", 32'(A), 32'h300000);
        check("post_rst_AV", 32'(A_VALID), 32'h0);

        // R low half 0x2A5 alone: A updates, A_VALID stays low
        SDRMPX = 1'b1; SDRAD_I = 8'hA5; SDRA_L = 2'd2;
        step(4);
        check("r_lo_A", 32'(A), 32'h3002A5);
        check("r_lo_AV", 32'(A_VALID), 32'h0);
        step(2);
        // R high half 0x155: {4'h3, 0x155, 0x2A5} = 24'h3556A5, valid SYNC_STAGES+2 after fall
        SDRMPX = 1'b0; SDRAD_I = 8'h55; SDRA_L = 2'd1;
        step(3);
        check("r_hi_AV_early", 32'(A_VALID), 32'h0);
        step(1);
        check("r_hi_A", 32'(A), 32'h3556A5);
        check("r_hi_AV", 32'(A_VALID), 32'h1);
        step(1);
        check("r_hi_AV_end", 32'(A_VALID), 32'h0);

        // Select P with MODE=1: one pulse, A = empty PLAT | offset
        MODE = 1'b1; nSDPOE = 1'b0;
        step(2);
        check("p_sel_POE", 32'(SDPAD_OE), 32'h1);
        step(1);
        check("p_sel_AV", 32'(A_VALID), 32'h1);
        check("p_sel_A", 32'(A), 32'h200000);
        step(1);
        check("p_sel_AV_end", 32'(A_VALID), 32'h0);
        SDPMPX = 1'b1; SDPA = 4'h4; SDPAD_I = 8'h56;
        step(6);
        SDPMPX = 1'b0; SDPA = 4'h1; SDPAD_I = 8'h23;
        step(4);
        check("p_hi_A_mode1", 32'(A), 32'h323456);
        check("p_hi_AV", 32'(A_VALID), 32'h1);
        MODE = 1'b0;
        step(2);
        check("p_A_mode0", 32'(A), 32'h123456);
        check("p_mode_AV", 32'(A_VALID), 32'h0);

        // Back to R: selection pulse and the retained R address
        nSDPOE = 1'b1;
        step(3);
        check("r_sel_AV", 32'(A_VALID), 32'h1);
        check("r_sel_A", 32'(A), 32'h3556A5);

        // Read hold: COUNT entered at edge 3, DLAT samples D at edge 8
        D = 8'h5A; nSDROE = 1'b0;
        step(2);
        check("rd_ROE", 32'(SDRAD_OE), 32'h1);
        step(1);
        D = 8'hC3;
        step(4);
        check("rd_count_pass", 32'(SDRAD_O), 32'hC3);
        D = 8'h3C;
        step(1);
        check("rd_hold_cap", 32'(SDRAD_O), 32'h3C);
        D = 8'h5A;
        step(1);
        check("rd_hold_keep", 32'(SDRAD_O), 32'h3C);
        check("pd_pass", 32'(SDPAD_O), 32'h5A);

        // P pre-empts R during COUNT
        nSDROE = 1'b1;
        step(4);
        check("rd_idle_pass", 32'(SDRAD_O), 32'h5A);
        nSDROE = 1'b0; D = 8'h77;
        step(4);
        nSDPOE = 1'b0;
        step(3);
        check("pre_AV", 32'(A_VALID), 32'h1);
        check("pre_A", 32'(A), 32'h123456);
        step(1);
        check("pre_AV_end", 32'(A_VALID), 32'h0);
        step(4);
        check("pre_frozen", 32'(SDRAD_O), 32'h77);
        nSDPOE = 1'b1;
        step(3);
        check("post_pre_AV", 32'(A_VALID), 32'h1);
        step(3);
        check("restart_count", 32'(SDRAD_O), 32'h77);
        D = 8'h99;
        step(1);
        check("restart_cap", 32'(SDRAD_O), 32'h99);
        D = 8'h42;
        step(1);
        check("restart_hold", 32'(SDRAD_O), 32'h99);

`ifdef PCM_BANK_EN
        BANK = 4'hA; MODE = 1'b1; nSDPOE = 1'b0;
        SDPMPX = 1'b1; SDPA = 4'h0; SDPAD_I = 8'h00;
        step(6);
        SDPMPX = 1'b0;
        step(4);
        check("bank_A", 32'(A), 32'hA00000);
        nSDPOE = 1'b1; MODE = 1'b0;
        step(4);
`endif

        // Asynchronous reset in the middle of a count
        nSDROE = 1'b1;
        step(4);
        nSDROE = 1'b0; D = 8'h66;
        step(5);
        #2 nRESET = 1'b0;
        #1;
        check("mid_rst_A", 32'(A), 32'h0);
        check("mid_rst_AV", 32'(A_VALID), 32'h0);
        check("mid_rst_ROE", 32'(SDRAD_OE), 32'h0);
        check("mid_rst_POE", 32'(SDPAD_OE), 32'h0);
        check("mid_rst_idle", 32'(SDRAD_O), 32'h66);
        step(1);
        nRESET = 1'b1;
        step(1);
        check("mid_rst_rlat", 32'(A), 32'h300000);
        nSDPOE = 1'b0;
        step(3);
        check("mid_rst_plat", 32'(A), 32'h000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
